// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths and shift-op encodings for the operand datapath
package datapath_pkg;
    localparam int DATA_W    = 16;
    localparam int NREGS     = 8;
    localparam int REG_IDX_W = 3;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;
endpackage

// File: rtl/regfile8x16.sv
// regfile8x16: 8 x 16 register file, one sync write port, one combinational read port
module regfile8x16
    import datapath_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 write,
    input  logic [REG_IDX_W-1:0] writenum,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [REG_IDX_W-1:0] readnum,
    output logic [DATA_W-1:0]    rdata
);
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // write decoder: only the addressed register takes data_in
    always_comb begin
        for (int i = 0; i < NREGS; i++)
            regs_d[i] = (write && writenum == REG_IDX_W'(i)) ? data_in : regs_q[i];
    end

    // storage with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;
    end

    // no write bypass: a same-cycle write becomes readable after the edge
    assign rdata = regs_q[readnum];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register file, A/B operand latches, B shifter and ALU input muxes
module operand_fetch
    import datapath_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 write,
    input  logic [REG_IDX_W-1:0] writenum,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [REG_IDX_W-1:0] readnum,
    input  logic                 loada,
    input  logic                 loadb,
    input  logic [1:0]           shift,
    input  logic                 asel,
    input  logic                 bsel,
    input  logic [DATA_W-1:0]    sximm5,
    output logic [DATA_W-1:0]    Ain,
    output logic [DATA_W-1:0]    Bin
);
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sh;

    regfile8x16 u_rf (
        .clk      (clk),
        .reset_n  (reset_n),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .readnum  (readnum),
        .rdata    (rdata)
    );

    // A/B latches capture the pre-write read data, otherwise hold
    always_comb begin
        a_d = loada ? rdata : a_q;
        b_d = loadb ? rdata : b_q;
    end

    // operand latch state with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // B-path shifter; shifted-out bits are dropped
    always_comb begin
        sh = (shift == SH_LSL) ? {b_q[DATA_W-2:0], 1'b0} :
             (shift == SH_LSR) ? {1'b0, b_q[DATA_W-1:1]} :
             (shift == SH_ASR) ? {b_q[DATA_W-1], b_q[DATA_W-1:1]} :
                                 b_q;
    end

    assign Ain = asel ? '0 : a_q;
    assign Bin = bsel ? sximm5 : sh;
endmodule
